// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared definitions for param_alu_seq and its multiplier.
//   * 5-bit opcode constants (0x00-0x0F single-cycle, 0x10 MUL)
//   * flag bit positions inside the 4-bit flags word {Z,C,N,O}
//   * FSM state enum
//   * flag_mask(): which flag bits an opcode is allowed to write
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [4:0] OP_MOVA = 5'h00;
   localparam logic [4:0] OP_MOVB = 5'h01;
   localparam logic [4:0] OP_NOTA = 5'h02;
   localparam logic [4:0] OP_NOTB = 5'h03;
   localparam logic [4:0] OP_ADD  = 5'h04;
   localparam logic [4:0] OP_ADC  = 5'h05;
   localparam logic [4:0] OP_SUB  = 5'h06;
   localparam logic [4:0] OP_AND  = 5'h07;
   localparam logic [4:0] OP_OR   = 5'h08;
   localparam logic [4:0] OP_XOR  = 5'h09;
   localparam logic [4:0] OP_NAND = 5'h0A;
   localparam logic [4:0] OP_LSL  = 5'h0B;
   localparam logic [4:0] OP_LSR  = 5'h0C;
   localparam logic [4:0] OP_ASR  = 5'h0D;
   localparam logic [4:0] OP_CSL  = 5'h0E;
   localparam logic [4:0] OP_CSR  = 5'h0F;
   localparam logic [4:0] OP_MUL  = 5'h10;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_EXEC_MUL = 1'b1
   } state_t;

   // Bit set = that flag is rewritten by the op; clear bits hold their value.
   function automatic logic [3:0] flag_mask(input logic [4:0] op);
      logic [3:0] m;
      m = 4'b0000;
      case (op)
         OP_MOVA, OP_MOVB, OP_NOTA, OP_NOTB,
         OP_AND, OP_OR, OP_XOR, OP_NAND:        m = 4'b1010;  // Z,N
         OP_ADD, OP_ADC, OP_SUB:                m = 4'b1111;  // Z,C,N,O
         OP_LSL, OP_LSR, OP_ASR, OP_CSL, OP_CSR: m = 4'b1110; // Z,C,N
         OP_MUL:                                m = 4'b1100;  // Z,C
         default:                               m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// -----------------------------------------------------------------------------
// alu_shift_add_mul -- unsigned iterative shift-add multiplier.
// Operands are captured when i_start is high; one multiplier bit is consumed
// per clock for WIDTH clocks, then o_done pulses for one cycle while o_prod
// holds the full 2*WIDTH-bit product.
// Ports:
//   i_clk   clock (rising edge)        i_rst  async active-high reset
//   i_start load operands, begin run   i_a/i_b WIDTH-bit operands
//   o_done  one-cycle completion pulse o_prod 2*WIDTH-bit product
// -----------------------------------------------------------------------------
module alu_shift_add_mul #(
   parameter int WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_prod
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_cnt;
   logic               r_run;
   logic               r_done;

   // Load on start, then add the shifted multiplicand for every set multiplier bit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b1;
         end else if (r_run) begin
            if (r_mplier[0]) begin
               r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + ONE;
            // Last bit consumed on this edge: product is final afterwards.
            if (r_cnt == LAST) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_done = r_done;
   assign o_prod = r_acc;

endmodule

// File: rtl/param_alu_seq.sv
// -----------------------------------------------------------------------------
// param_alu_seq -- sequenced ALU with 16 single-cycle ops and an optional
// iterative unsigned multiplier (op 0x10).
// Build option: define ALU_MUL_EN to include the multiplier; without it op
// 0x10 is illegal, ResultHi is 0 and Busy is 0.
// Ports:
//   Clock     rising-edge clock           Reset    async active-high reset
//   Start     request (sampled in IDLE)   Op       5-bit opcode
//   A, B      WIDTH-bit operands          WF       flag write enable
//   Result    registered result / product low half
//   ResultHi  product high half (0 after non-MUL ops)
//   Busy      high while multiplying      Done     completion pulse
//   Err       illegal-op pulse            FlagsOut {Z,C,N,O}
// -----------------------------------------------------------------------------
module param_alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [4:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             WF,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] ResultHi,
   output logic             Busy,
   output logic             Done,
   output logic             Err,
   output logic [3:0]       FlagsOut
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;
   logic             r_done;
   logic             r_err;

   logic             w_accept;
   logic             w_is_mul;
   logic             w_illegal;
   logic             w_mul_finish;
   logic [WIDTH-1:0] w_opb;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_o;
   logic [3:0]       w_cand;
   logic [3:0]       w_mask;
   logic [3:0]       w_flags_nxt;

   assign w_accept = Start && (r_state == ST_IDLE);

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0]   r_resulthi;
   logic               r_wf;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_prod;
   logic [3:0]         w_mul_cand;
   logic [3:0]         w_mul_flags;

   assign w_is_mul     = (Op == OP_MUL);
   assign w_illegal    = (Op > OP_MUL);
   assign w_mul_finish = (r_state == ST_EXEC_MUL) && w_mul_done;

   alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .i_clk   (Clock),
      .i_rst   (Reset),
      .i_start (w_accept && w_is_mul),
      .i_a     (A),
      .i_b     (B),
      .o_done  (w_mul_done),
      .o_prod  (w_prod)
   );

   // MUL: Z covers the full double-width product, C flags a nonzero high half.
   assign w_mul_cand  = {(w_prod == '0), (w_prod[2*WIDTH-1:WIDTH] != '0), 2'b00};
   assign w_mul_flags = (r_flags & ~flag_mask(OP_MUL)) | (w_mul_cand & flag_mask(OP_MUL));

   // WF is latched at acceptance; ResultHi clears on single-cycle ops.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_resulthi <= '0;
         r_wf       <= 1'b0;
      end else begin
         if (w_accept && w_is_mul) begin
            r_wf <= WF;
         end
         if (w_accept && !w_illegal && !w_is_mul) begin
            r_resulthi <= '0;
         end else if (w_mul_finish) begin
            r_resulthi <= w_prod[2*WIDTH-1:WIDTH];
         end
      end
   end

   assign Busy     = (r_state == ST_EXEC_MUL);
   assign ResultHi = r_resulthi;
`else
   assign w_is_mul     = 1'b0;
   assign w_illegal    = (Op >= OP_MUL);
   assign w_mul_finish = 1'b0;
   assign Busy         = 1'b0;
   assign ResultHi     = '0;
`endif

   // Single-cycle datapath; SUB reuses the adder as A + ~B + 1.
   always_comb begin
      w_opb = B;
      w_cin = 1'b0;
      w_res = '0;
      w_c   = r_flags[FLAG_C];
      w_o   = r_flags[FLAG_O];
      if (Op == OP_SUB) begin
         w_opb = ~B;
         w_cin = 1'b1;
      end else if (Op == OP_ADC) begin
         w_opb = B;
         w_cin = r_flags[FLAG_C];
      end else begin
         w_opb = B;
         w_cin = 1'b0;
      end
      w_sum = {1'b0, A} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
      case (Op)
         OP_MOVA: w_res = A;
         OP_MOVB: w_res = B;
         OP_NOTA: w_res = ~A;
         OP_NOTB: w_res = ~B;
         OP_ADD, OP_ADC: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_o   = (A[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = ~w_sum[WIDTH];  // borrow
            w_o   = (A[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  w_res = A & B;
         OP_OR:   w_res = A | B;
         OP_XOR:  w_res = A ^ B;
         OP_NAND: w_res = ~(A & B);
         OP_LSL: begin
            w_res = {A[WIDTH-2:0], 1'b0};
            w_c   = A[WIDTH-1];
         end
         OP_LSR: begin
            w_res = {1'b0, A[WIDTH-1:1]};
            w_c   = A[0];
         end
         OP_ASR: begin
            w_res = {A[WIDTH-1], A[WIDTH-1:1]};
            w_c   = A[0];
         end
         OP_CSL: begin
            w_res = {A[WIDTH-2:0], r_flags[FLAG_C]};
            w_c   = A[WIDTH-1];
         end
         OP_CSR: begin
            w_res = {r_flags[FLAG_C], A[WIDTH-1:1]};
            w_c   = A[0];
         end
         default: w_res = '0;
      endcase
      w_cand      = {(w_res == '0), w_c, w_res[WIDTH-1], w_o};
      w_mask      = flag_mask(Op);
      w_flags_nxt = (r_flags & ~w_mask) | (w_cand & w_mask);
   end

   // FSM state register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: only MUL leaves IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && w_is_mul) begin
               w_state_nxt = ST_EXEC_MUL;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_EXEC_MUL: begin
            if (w_mul_finish) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_EXEC_MUL;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Result, flags and the Done/Err pulses.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_result <= '0;
         r_flags  <= 4'b0000;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_accept && w_illegal) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
         end else if (w_accept && !w_is_mul) begin
            r_result <= w_res;
            r_done   <= 1'b1;
            if (WF) begin
               r_flags <= w_flags_nxt;
            end
         end
`ifdef ALU_MUL_EN
         else if (w_mul_finish) begin
            r_result <= w_prod[WIDTH-1:0];
            r_done   <= 1'b1;
            if (r_wf) begin
               r_flags <= w_mul_flags;
            end
         end
`endif
      end
   end

   assign Result   = r_result;
   assign Done     = r_done;
   assign Err      = r_err;
   assign FlagsOut = r_flags;

endmodule

// File: doc/param_alu_seq.md
PARAM_ALU_SEQ -- requirements
Module: param_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits; legal values are even and at least 8.
REQ-002 SHALL have port Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port Op  input  5  operation code, captured on accepted Start.
REQ-006 SHALL have ports A, B  input  WIDTH  operands, captured on accepted Start.
REQ-007 SHALL have port WF  input  1  flag write enable, captured on accepted Start.
REQ-008 SHALL have port Result  output  WIDTH  registered result (low half for MUL).
REQ-009 SHALL have port ResultHi  output  WIDTH  registered upper product half; 0 for non-MUL ops.
REQ-010 SHALL have ports Busy, Done, Err  output  1 each  in-progress level, completion pulse, illegal-op pulse.
REQ-011 SHALL have port FlagsOut  output  4  registered flags {Z,C,N,O}, bit 3 down to bit 0.

Function
REQ-012 SHALL implement a state machine IDLE -> (EXEC_MUL) -> IDLE; Busy=1 exactly while in EXEC_MUL.
REQ-013 SHALL treat Start in IDLE as accepted and SHALL ignore Start while Busy=1.
REQ-014 Op 0x00-0x0F SHALL be single-cycle: A, B, ~A, ~B, ADD, ADC, SUB, AND, OR, XOR, NAND, LSL, LSR, ASR, CSL, CSR, all over full WIDTH.
REQ-015 Single-cycle ops SHALL update Result and pulse Done for one cycle at the edge that accepts Start; no state change.
REQ-016 Op 0x10 (MUL) SHALL run unsigned shift-add, one bit per cycle, for WIDTH cycles in EXEC_MUL; the Done pulse occurs WIDTH+1 edges after the accepting edge, with {ResultHi,Result} = A*B.
REQ-017 Captured operands SHALL be used; changes to A/B/Op/WF after acceptance SHALL have no effect.
REQ-018 Op 0x11-0x1F SHALL pulse Done and Err together; Result, ResultHi and FlagsOut are unchanged.
REQ-019 ADD/ADC SHALL set C to the carry out of bit WIDTH-1; ADC adds FlagsOut C; O = signed overflow.
REQ-020 SUB SHALL compute A+~B+1 with C = borrow (inverted carry) and O = signed overflow.
REQ-021 LSL SHALL set C=A[W-1]; LSR SHALL set C=A[0] with MSB 0; ASR SHALL replicate A[W-1] and set C=A[0].
REQ-022 CSL SHALL produce {A[W-2:0],C} with new C=A[W-1]; CSR SHALL produce {C,A[W-1:1]} with new C=A[0].
REQ-023 When captured WF=1, flags SHALL update with the Done pulse: logic/move ops Z,N; arithmetic Z,C,N,O; shifts Z,C,N; MUL Z (full 2W product zero) and C (ResultHi nonzero). Untouched bits hold.
REQ-024 Z SHALL reflect Result==0 (single-cycle); N SHALL be Result[WIDTH-1].
REQ-025 When captured WF=0, FlagsOut SHALL be unchanged.

Reset
REQ-026 Reset SHALL force IDLE, Busy=0, Done=0, Err=0, Result=0, ResultHi=0, FlagsOut=0 immediately, without waiting for Clock.
REQ-027 Reset during EXEC_MUL SHALL abort it with no Done pulse; the first edge after release may accept Start.

Configuration
REQ-028 With macro ALU_MUL_EN defined, op 0x10 SHALL behave per REQ-016.
REQ-029 Without ALU_MUL_EN, no multiplier logic SHALL exist, op 0x10 SHALL be illegal per REQ-018, ResultHi SHALL be tied 0 and Busy SHALL be constant 0.

Structure
REQ-030 A shared package alu_pkg SHALL hold opcode constants, flag bit indices (Z=3,C=2,N=1,O=0) and the state enum.
REQ-031 The multiplier SHALL be the sub-module alu_shift_add_mul (start, WIDTH-cycle iterative datapath, done), instantiated only under ALU_MUL_EN.

Verification (WIDTH=16)
REQ-032 ADD A=0x7FFF B=0x0001 WF=1 -> next edge: Result=0x8000, Done=1, FlagsOut=4'b0011.
REQ-033 SUB A=0x0000 B=0x0001 WF=1 -> Result=0xFFFF, FlagsOut=4'b0110 (Z=0,C=1,N=1,O=0).
REQ-034 MUL A=0xFFFF B=0xFFFF -> Busy for 16 cycles, Done at edge 17: ResultHi=0xFFFE, Result=0x0001, C=1, Z=0; Start pulses while Busy ignored.
REQ-035 CSR with C=1, A=0x0002 -> Result=0x8001, C=0, N=1; then Op=0x15 -> Done=1, Err=1, Result stays 0x8001.
REQ-036 Reset asserted at MUL cycle 8 -> outputs zero asynchronously, no Done; new ADD after release completes normally.
